// File: rtl/ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | ctrl_pkg: shared opcodes, control codes and FSM encoding           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [2:0] ALU_RTYPE = 3'd0;
    localparam logic [2:0] ALU_LOAD  = 3'd1;
    localparam logic [2:0] ALU_JALR  = 3'd2;
    localparam logic [2:0] ALU_OPIMM = 3'd3;
    localparam logic [2:0] ALU_ADD   = 3'd4;
    localparam logic [2:0] ALU_LUI   = 3'd5;
    localparam logic [2:0] ALU_MDU   = 3'd6;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_U = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    typedef struct packed {
        logic       write_en;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       jump;
        logic       pc_select;
        logic       imm_select;
        logic       jal_select;
        logic       data_mem_select;
        logic [2:0] imm_pick;
        logic [2:0] alu_op;
        logic       mdu_en;
        logic [2:0] mdu_op;
        logic       illegal;
    } ctrl_t;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MDU_BUSY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// +--------------------------------------------------------------------+
// | ctrl_decode: combinational RV32IM control decode                   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output ctrl_t      ctrl,
    output logic       is_div
);

    logic w_legal;

    always_comb begin
        ctrl    = '0;
        is_div  = 1'b0;
        w_legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (func7 == F7_MEXT) begin
                    // Write enable is masked by the stage until the op completes
                    ctrl.write_en = 1'b1;
                    ctrl.mdu_en   = 1'b1;
                    ctrl.mdu_op   = func3;
                    ctrl.alu_op   = ALU_MDU;
                    is_div        = func3[2];
                    w_legal       = 1'b1;
                end else if (func7 == F7_BASE ||
                             (func7 == F7_ALT && (func3 == 3'b000 || func3 == 3'b101))) begin
                    ctrl.write_en = 1'b1;
                    ctrl.alu_op   = ALU_RTYPE;
                    w_legal       = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (func3 != 3'b011 && func3 != 3'b110 && func3 != 3'b111) begin
                    ctrl.write_en        = 1'b1;
                    ctrl.mem_read        = 1'b1;
                    ctrl.imm_select      = 1'b1;
                    ctrl.data_mem_select = 1'b1;
                    ctrl.imm_pick        = IMM_I;
                    ctrl.alu_op          = ALU_LOAD;
                    w_legal              = 1'b1;
                end
            end
            OPC_JALR: begin
                if (func3 == 3'b000) begin
                    ctrl.write_en   = 1'b1;
                    ctrl.jump       = 1'b1;
                    ctrl.pc_select  = 1'b1;
                    ctrl.imm_select = 1'b1;
                    ctrl.jal_select = 1'b1;
                    ctrl.imm_pick   = IMM_I;
                    ctrl.alu_op     = ALU_JALR;
                    w_legal         = 1'b1;
                end
            end
            OPC_OPIMM: begin
                // Shift-immediates carry the shift type in func7
                if ((func3 == 3'b001 && func7 == F7_BASE) ||
                    (func3 == 3'b101 && (func7 == F7_BASE || func7 == F7_ALT)) ||
                    (func3 != 3'b001 && func3 != 3'b101)) begin
                    ctrl.write_en   = 1'b1;
                    ctrl.imm_select = 1'b1;
                    ctrl.imm_pick   = IMM_I;
                    ctrl.alu_op     = ALU_OPIMM;
                    w_legal         = 1'b1;
                end
            end
            OPC_STORE: begin
                if (func3 == 3'b000 || func3 == 3'b001 || func3 == 3'b010) begin
                    ctrl.mem_write  = 1'b1;
                    ctrl.imm_select = 1'b1;
                    ctrl.imm_pick   = IMM_S;
                    ctrl.alu_op     = ALU_ADD;
                    w_legal         = 1'b1;
                end
            end
            OPC_LUI: begin
                ctrl.write_en   = 1'b1;
                ctrl.imm_select = 1'b1;
                ctrl.imm_pick   = IMM_U;
                ctrl.alu_op     = ALU_LUI;
                w_legal         = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.write_en   = 1'b1;
                ctrl.imm_select = 1'b1;
                ctrl.imm_pick   = IMM_U;
                ctrl.alu_op     = ALU_ADD;
                w_legal         = 1'b1;
            end
            OPC_BRANCH: begin
                if (func3 != 3'b010 && func3 != 3'b011) begin
                    ctrl.branch   = 1'b1;
                    ctrl.imm_pick = IMM_B;
                    ctrl.alu_op   = ALU_ADD;
                    w_legal       = 1'b1;
                end
            end
            OPC_JAL: begin
                ctrl.write_en   = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.pc_select  = 1'b1;
                ctrl.imm_select = 1'b1;
                ctrl.jal_select = 1'b1;
                ctrl.imm_pick   = IMM_J;
                ctrl.alu_op     = ALU_ADD;
                w_legal         = 1'b1;
            end
            default: begin
            end
        endcase
        if (!w_legal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            is_div       = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_ctrl_stage.sv
// +--------------------------------------------------------------------+
// | decode_ctrl_stage: ID control register with multi-cycle MDU hold   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module decode_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 4,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 33
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    input  logic [6:0]          opcode,
    input  logic [2:0]          func3,
    input  logic [6:0]          func7,
    input  logic                hold_in,
    input  logic                flush,
    output logic                write_en,
    output logic                mem_write,
    output logic                mem_read,
    output logic                branch,
    output logic                jump,
    output logic                pc_select,
    output logic                imm_select,
    output logic                jal_select,
    output logic                data_mem_select,
    output logic [2:0]          imm_pick,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mdu_en,
    output logic [2:0]          mdu_op,
    output logic                out_valid,
    output logic                illegal,
    output logic                stall_out
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] C_MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] C_DIV_INIT = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    ctrl_t              w_dec;
    logic               w_is_div;
    logic               w_counting;
    logic [CNT_W-1:0]   w_lat_init;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    ctrl_t              r_ctrl;
    logic               r_out_valid;

    ctrl_decode u_decode (
        .opcode (opcode),
        .func3  (func3),
        .func7  (func7),
        .ctrl   (w_dec),
        .is_div (w_is_div)
    );

    assign w_counting = (r_state == ST_MDU_BUSY) && (r_cnt != '0);
    assign w_lat_init = w_is_div ? C_DIV_INIT : C_MUL_INIT;
    assign stall_out  = w_counting || hold_in;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ctrl      <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ctrl      <= '0;
            r_out_valid <= 1'b0;
        end else if (w_counting) begin
            // MDU count runs even under downstream hold; write fires on the last cycle
            r_cnt           <= r_cnt - C_CNT_ONE;
            r_ctrl.write_en <= (r_cnt == C_CNT_ONE);
        end else if (hold_in) begin
            r_state <= r_state;
        end else if (in_valid) begin
            r_ctrl      <= w_dec;
            r_out_valid <= 1'b1;
            if (w_dec.mdu_en) begin
                r_state         <= ST_MDU_BUSY;
                r_cnt           <= w_lat_init;
                r_ctrl.write_en <= (w_lat_init == '0);
            end else begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end
        end else begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ctrl      <= '0;
            r_out_valid <= 1'b0;
        end
    end

    assign write_en        = r_ctrl.write_en;
    assign mem_write       = r_ctrl.mem_write;
    assign mem_read        = r_ctrl.mem_read;
    assign branch          = r_ctrl.branch;
    assign jump            = r_ctrl.jump;
    assign pc_select       = r_ctrl.pc_select;
    assign imm_select      = r_ctrl.imm_select;
    assign jal_select      = r_ctrl.jal_select;
    assign data_mem_select = r_ctrl.data_mem_select;
    assign imm_pick        = r_ctrl.imm_pick;
    assign alu_op          = ALU_OP_W'(r_ctrl.alu_op);
    assign mdu_en          = r_ctrl.mdu_en;
    assign mdu_op          = r_ctrl.mdu_op;
    assign illegal         = r_ctrl.illegal;
    assign out_valid       = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_decode_ctrl_stage.sv
// +--------------------------------------------------------------------+
// | tb_decode_ctrl_stage: directed checks on three latency configs     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_decode_ctrl_stage;

    logic       clk = 1'b0;
    logic       resetn, in_valid, hold_in, flush;
    logic [6:0] opcode, func7;
    logic [2:0] func3;

    logic       write_en [3];
    logic       mem_write [3];
    logic       mem_read [3];
    logic       branch [3];
    logic       jump [3];
    logic       pc_select [3];
    logic       imm_select [3];
    logic       jal_select [3];
    logic       data_mem_select [3];
    logic [2:0] imm_pick [3];
    logic [3:0] alu_op [3];
    logic       mdu_en [3];
    logic [2:0] mdu_op [3];
    logic       out_valid [3];
    logic       illegal [3];
    logic       stall_out [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instance 0: MUL_LAT=2, 1: MUL_LAT=1, 2: MUL_LAT=4; all DIV_LAT=33
    for (genvar g = 0; g < 3; g++) begin : g_dut
        decode_ctrl_stage #(
            .ALU_OP_W (4),
            .MUL_LAT  ((g == 0) ? 2 : (g == 1) ? 1 : 4),
            .DIV_LAT  (33)
        ) u_dut (
            .clk             (clk),
            .resetn          (resetn),
            .in_valid        (in_valid),
            .opcode          (opcode),
            .func3           (func3),
            .func7           (func7),
            .hold_in         (hold_in),
            .flush           (flush),
            .write_en        (write_en[g]),
            .mem_write       (mem_write[g]),
            .mem_read        (mem_read[g]),
            .branch          (branch[g]),
            .jump            (jump[g]),
            .pc_select       (pc_select[g]),
            .imm_select      (imm_select[g]),
            .jal_select      (jal_select[g]),
            .data_mem_select (data_mem_select[g]),
            .imm_pick        (imm_pick[g]),
            .alu_op          (alu_op[g]),
            .mdu_en          (mdu_en[g]),
            .mdu_op          (mdu_op[g]),
            .out_valid       (out_valid[g]),
            .illegal         (illegal[g]),
            .stall_out       (stall_out[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int g);
        return {10'b0, write_en[g], mem_write[g], mem_read[g], branch[g], jump[g],
                pc_select[g], imm_select[g], jal_select[g], data_mem_select[g],
                imm_pick[g], alu_op[g], mdu_en[g], mdu_op[g], out_valid[g], illegal[g]};
    endfunction

    function automatic logic [31:0] ev(input int we, input int mw, input int mr, input int br,
                                       input int jp, input int pcs, input int ims, input int jls,
                                       input int dms, input int pick, input int aop,
                                       input int mden, input int mdop, input int ov, input int ill);
        return {10'b0, we[0], mw[0], mr[0], br[0], jp[0], pcs[0], ims[0], jls[0], dms[0],
                pick[2:0], aop[3:0], mden[0], mdop[2:0], ov[0], ill[0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        in_valid = 1'b1;
        opcode   = op;
        func3    = f3;
        func7    = f7;
    endtask

    task automatic apply_chk(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] exp);
        present(op, f3, f7);
        step();
        chk(tag, obs(0), exp);
    endtask

    task automatic reset_pulse();
        resetn   = 1'b0;
        in_valid = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    logic [31:0] e_addi, e_ill, e_div;

    initial begin
        e_addi = ev(1,0,0,0,0,0,1,0,0,0,3,0,0,1,0);
        e_ill  = ev(0,0,0,0,0,0,0,0,0,0,0,0,0,1,1);
        e_div  = ev(0,0,0,0,0,0,0,0,0,0,6,1,4,1,0);
        resetn = 1'b0; in_valid = 1'b0; hold_in = 1'b0; flush = 1'b0;
        opcode = '0; func3 = '0; func7 = '0;
        step(); step();
        chk("reset_outs", obs(0), 32'h0);
        chk("reset_stall", 32'(stall_out[0]), 32'h0);

        // First accept on the first edge after release
        resetn = 1'b1;
        apply_chk("addi", 7'b0010011, 3'b000, 7'h00, e_addi);
        chk("addi_stall", 32'(stall_out[0]), 32'h0);
        apply_chk("lw",    7'b0000011, 3'b010, 7'h00, ev(1,0,1,0,0,0,1,0,1,0,1,0,0,1,0));
        apply_chk("lui",   7'b0110111, 3'b000, 7'h00, ev(1,0,0,0,0,0,1,0,0,2,5,0,0,1,0));
        apply_chk("auipc", 7'b0010111, 3'b000, 7'h00, ev(1,0,0,0,0,0,1,0,0,2,4,0,0,1,0));
        apply_chk("beq",   7'b1100011, 3'b000, 7'h00, ev(0,0,0,1,0,0,0,0,0,3,4,0,0,1,0));
        apply_chk("jal",   7'b1101111, 3'b000, 7'h00, ev(1,0,0,0,1,1,1,1,0,4,4,0,0,1,0));
        apply_chk("jalr",  7'b1100111, 3'b000, 7'h00, ev(1,0,0,0,1,1,1,1,0,0,2,0,0,1,0));
        apply_chk("srai",  7'b0010011, 3'b101, 7'h20, e_addi);
        apply_chk("sub",   7'b0110011, 3'b000, 7'h20, ev(1,0,0,0,0,0,0,0,0,0,0,0,0,1,0));
        apply_chk("sb",    7'b0100011, 3'b000, 7'h00, ev(0,1,0,0,0,0,1,0,0,1,4,0,0,1,0));
        apply_chk("sll_alt_ill", 7'b0110011, 3'b001, 7'h20, e_ill);
        in_valid = 1'b0;
        step();
        chk("bubble", obs(0), 32'h0);

        // DIV: 32 stalled cycles, then a single write cycle
        apply_chk("div_acc", 7'b0110011, 3'b100, 7'h01, e_div);
        chk("div_stall0", 32'(stall_out[0]), 32'h1);
        present(7'b0110011, 3'b000, 7'h00);
        for (int i = 0; i < 31; i++) begin
            step();
            chk("div_stall", 32'(stall_out[0]), 32'h1);
            chk("div_we_low", 32'(write_en[0]), 32'h0);
        end
        step();
        chk("div_done", obs(0), ev(1,0,0,0,0,0,0,0,0,0,6,1,4,1,0));
        chk("div_done_stall", 32'(stall_out[0]), 32'h0);
        step();
        chk("add_after_div", obs(0), ev(1,0,0,0,0,0,0,0,0,0,0,0,0,1,0));

        // FLUSH mid-DIV, with an instruction presented alongside it
        apply_chk("div2_acc", 7'b0110011, 3'b100, 7'h01, e_div);
        present(7'b0110011, 3'b000, 7'h00);
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_bubble", obs(0), 32'h0);
        chk("flush_stall", 32'(stall_out[0]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_we", 32'(write_en[0]), 32'h0);
        end

        // HOLD together with FLUSH resolves to flush
        apply_chk("addi2", 7'b0010011, 3'b000, 7'h00, e_addi);
        hold_in = 1'b1;
        flush   = 1'b1;
        step();
        chk("hold_flush", obs(0), 32'h0);
        hold_in = 1'b0;
        flush   = 1'b0;

        // Illegal opcode, then frozen under HOLD
        apply_chk("illegal", 7'b1111111, 3'b000, 7'h00, e_ill);
        hold_in = 1'b1;
        present(7'b0010011, 3'b000, 7'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_frozen", obs(0), e_ill);
            chk("hold_stall", 32'(stall_out[0]), 32'h1);
        end
        hold_in = 1'b0;
        step();
        chk("after_hold", obs(0), e_addi);

        // MUL_LAT=1 then back-to-back SW
        reset_pulse();
        present(7'b0110011, 3'b000, 7'h01);
        step();
        chk("mul1", obs(1), ev(1,0,0,0,0,0,0,0,0,0,6,1,0,1,0));
        chk("mul1_stall", 32'(stall_out[1]), 32'h0);
        present(7'b0100011, 3'b010, 7'h00);
        step();
        chk("sw_after_mul1", obs(1), ev(0,1,0,0,0,0,1,0,0,1,4,0,0,1,0));

        // MUL_LAT=4: HOLD does not pause the count
        reset_pulse();
        present(7'b0110011, 3'b011, 7'h01);
        step();
        chk("mulhu_acc", obs(2), ev(0,0,0,0,0,0,0,0,0,0,6,1,3,1,0));
        chk("mulhu_stall", 32'(stall_out[2]), 32'h1);
        in_valid = 1'b0;
        hold_in  = 1'b1;
        repeat (3) step();
        chk("mul_hold_count", 32'(write_en[2]), 32'h1);
        hold_in = 1'b0;
        step();
        chk("mul_then_bubble", obs(2), 32'h0);

        // Asynchronous reset mid-MUL
        present(7'b0110011, 3'b000, 7'h01);
        step();
        in_valid = 1'b0;
        step();
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_outs", obs(2), 32'h0);
        chk("async_rst_stall", 32'(stall_out[2]), 32'h0);
        step();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_we", 32'(write_en[2]), 32'h0);
        end
        present(7'b0010011, 3'b000, 7'h00);
        step();
        chk("addi_after_rst", obs(2), e_addi);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
